// File: rtl/commit_trace_unit.sv
// Commit/trace recorder: packs each retire-side event cycle into a record, queues it
// for a valid/ready trace sink, and keeps saturating performance counters until halt.
module commit_trace_unit #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reg_wr,
    input  logic [2:0]       wr_reg,
    input  logic [15:0]      wr_data,
    input  logic             mem_rd,
    input  logic             mem_wr,
    input  logic [15:0]      mem_addr,
    input  logic [15:0]      mem_wdata,
    input  logic [15:0]      mem_rdata,
    input  logic             halt,
    input  logic             ic_req,
    input  logic             ic_hit,
    input  logic             dc_req,
    input  logic             dc_hit,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [70:0]      rec_data,
    output logic             overflow,
    output logic             done,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] inst_cnt,
    output logic [CNT_W-1:0] ic_req_cnt,
    output logic [CNT_W-1:0] ic_hit_cnt,
    output logic [CNT_W-1:0] dc_req_cnt,
    output logic [CNT_W-1:0] dc_hit_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int REC_W = 71;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_r;
    logic [REC_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_next_s;
    logic [PTR_W:0]   count_r;
    logic [PTR_W:0]   count_after_pop_s;
    logic [PTR_W:0]   count_next_s;
    logic [REC_W-1:0] rec_s;
    logic [REC_W-1:0] head_next_s;
    logic             capture_s;
    logic             pop_s;
    logic             full_s;
    logic             push_s;
    logic             drop_s;
    logic             inst_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic en);
        if (en && (cnt != {CNT_W{1'b1}})) begin
            sat_inc = cnt + CNT_W'(1);
        end else begin
            sat_inc = cnt;
        end
    endfunction

    // Capture/drain decisions and the next FIFO head, which is registered so rec_data is a flop output.
    always_comb begin
        rec_s             = {halt, mem_wr, mem_rd, reg_wr, wr_reg, wr_data, mem_addr, mem_wdata, mem_rdata};
        capture_s         = (state_r == ST_RUN) && (reg_wr || mem_rd || mem_wr || halt);
        pop_s             = rec_valid && rec_ready;
        full_s            = (count_r == (PTR_W+1)'(DEPTH));
        push_s            = capture_s && (!full_s || pop_s);
        drop_s            = capture_s && full_s && !pop_s;
        inst_s            = halt || reg_wr || mem_wr;
        rd_ptr_next_s     = pop_s ? (rd_ptr_r + PTR_W'(1)) : rd_ptr_r;
        count_after_pop_s = count_r - {{PTR_W{1'b0}}, pop_s};
        count_next_s      = count_after_pop_s + {{PTR_W{1'b0}}, push_s};
        if (push_s && (count_after_pop_s == {(PTR_W+1){1'b0}})) begin
            head_next_s = rec_s;
        end else begin
            head_next_s = mem_r[rd_ptr_next_s];
        end
    end

    // Record storage; a push into a full FIFO with a pop reuses the slot being vacated.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= rec_s;
        end
    end

    // Run/drain/done sequencing, FIFO pointers, registered outputs and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_RUN;
            rd_ptr_r   <= {PTR_W{1'b0}};
            wr_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {(PTR_W+1){1'b0}};
            rec_valid  <= 1'b0;
            rec_data   <= {REC_W{1'b0}};
            overflow   <= 1'b0;
            done       <= 1'b0;
            cycle_cnt  <= {CNT_W{1'b0}};
            inst_cnt   <= {CNT_W{1'b0}};
            ic_req_cnt <= {CNT_W{1'b0}};
            ic_hit_cnt <= {CNT_W{1'b0}};
            dc_req_cnt <= {CNT_W{1'b0}};
            dc_hit_cnt <= {CNT_W{1'b0}};
        end else begin
            rd_ptr_r  <= rd_ptr_next_s;
            wr_ptr_r  <= push_s ? (wr_ptr_r + PTR_W'(1)) : wr_ptr_r;
            count_r   <= count_next_s;
            rec_valid <= (count_next_s != {(PTR_W+1){1'b0}});
            rec_data  <= head_next_s;
            if (drop_s) begin
                overflow <= 1'b1;
            end
            case (state_r)
                ST_RUN: begin
                    cycle_cnt  <= sat_inc(cycle_cnt, 1'b1);
                    inst_cnt   <= sat_inc(inst_cnt, inst_s);
                    ic_req_cnt <= sat_inc(ic_req_cnt, ic_req);
                    ic_hit_cnt <= sat_inc(ic_hit_cnt, ic_hit);
                    dc_req_cnt <= sat_inc(dc_req_cnt, dc_req);
                    dc_hit_cnt <= sat_inc(dc_hit_cnt, dc_hit);
                    if (halt) begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Covers the dropped-halt case too: an empty FIFO finishes on the first drain cycle.
                    if (count_next_s == {(PTR_W+1){1'b0}}) begin
                        state_r <= ST_DONE;
                        done    <= 1'b1;
                    end
                end
                ST_DONE: begin
                    done <= 1'b1;
                end
                default: begin
                    state_r <= ST_RUN;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
